// File: rtl/gray_counter_encoder.sv
// Up/down binary counter with a registered Gray-code copy and wrap pulse.
// binary and gray are both loaded from the same next-state value, so they never skew.
module gray_counter_encoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        binary_d = binary_q;
        wrap_d   = 1'b0;
        if (load) begin
            binary_d = load_bin;
        end else if (en && up) begin
            binary_d = binary_q + 1'b1;
            wrap_d   = &binary_q;
        end else if (en) begin
            binary_d = binary_q - 1'b1;
            wrap_d   = ~|binary_q;
        end
        // Encode the next value so the Gray register lands in the same edge as binary.
        gray_d = binary_d ^ (binary_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary_q <= '0;
            gray_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            wrap_q   <= wrap_d;
        end
    end

    assign binary = binary_q;
    assign gray   = gray_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_counter_encoder.sv
// Scoreboard bench for gray_counter_encoder (WIDTH=4): driver pushes expected
// results, a monitor pops one entry after every clock edge that has one pending.
module tb_gray_counter_encoder;

    logic       clk, rst, en, up, load;
    logic [3:0] load_bin, binary, gray;
    logic       wrap;

    gray_counter_encoder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .binary(binary), .gray(gray), .wrap(wrap)
    );

    typedef struct {
        logic [3:0] b;
        logic [3:0] g;
        logic       w;
        bit         chk_g;
        bit         onebit;
        bit         rt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [3:0] prev_g = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] b, input logic [3:0] g, input logic w,
                                input bit onebit);
        exp_t x;
        x.b = b; x.g = g; x.w = w; x.chk_g = 1'b1; x.onebit = onebit; x.rt = 1'b0;
        return x;
    endfunction

    task automatic drive(input logic e, input logic u, input logic l,
                         input logic [3:0] lb, input exp_t x);
        @(negedge clk);
        en = e; up = u; load = l; load_bin = lb;
        sb.push_back(x);
    endtask

    // Idle the inputs and wait (bounded) for the monitor to consume everything.
    task automatic drain();
        @(negedge clk);
        en = 1'b0; up = 1'b0; load = 1'b0; load_bin = 4'd0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: independent Gray-to-binary decode for round-trip entries.
    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            exp_t x;
            logic [3:0] dec;
            x = sb.pop_front();
            chk("binary", binary, x.b);
            chk("wrap", wrap, x.w);
            if (x.chk_g) chk("gray", gray, x.g);
            if (x.onebit) chk("gray_one_bit_flip", $countones(gray ^ prev_g), 1);
            if (x.rt) begin
                dec[3] = gray[3];
                for (int k = 2; k >= 0; k--) dec[k] = dec[k+1] ^ gray[k];
                chk("round_trip", dec, binary);
            end
        end
        prev_g = gray;
    end

    logic [3:0] gtab [0:16];
    logic [3:0] mb, nb;
    logic       e, u, l, mw;
    logic [3:0] lb;

    initial begin
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                 4'b0000};
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_binary", binary, 0);
        chk("reset_gray", gray, 0);
        chk("reset_wrap", wrap, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-count at binary=5
        drive(1'b0, 1'b0, 1'b1, 4'b0101, mk(4'b0101, 4'b0111, 1'b0, 1'b0));
        drain();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_binary", binary, 0);
        chk("async_rst_gray", gray, 0);
        chk("async_rst_wrap", wrap, 0);
        load = 1'b1; load_bin = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_binary", binary, 0);
        chk("rst_hold_gray", gray, 0);
        @(negedge clk);
        load = 1'b0; load_bin = 4'd0;
        rst = 1'b0;

        // Up sweep from 0 through the wrap
        for (int k = 0; k < 16; k++)
            drive(1'b1, 1'b1, 1'b0, 4'd0,
                  mk(4'((k + 1) % 16), gtab[k+1], (k == 15), 1'b1));
        drive(1'b0, 1'b0, 1'b0, 4'd0, mk(4'b0000, 4'b0000, 1'b0, 1'b0));
        drain();

        // Down wrap
        drive(1'b0, 1'b0, 1'b1, 4'b0001, mk(4'b0001, 4'b0001, 1'b0, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 4'd0,    mk(4'b0000, 4'b0000, 1'b0, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 4'd0,    mk(4'b1111, 4'b1000, 1'b1, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 4'd0,    mk(4'b1111, 4'b1000, 1'b0, 1'b0));
        drain();

        // Load beats en
        drive(1'b0, 1'b0, 1'b1, 4'b0011, mk(4'b0011, 4'b0010, 1'b0, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 4'b1010, mk(4'b1010, 4'b1111, 1'b0, 1'b0));
        drain();

        // Load of all-ones with en up: no wrap because the load wins
        drive(1'b0, 1'b0, 1'b1, 4'b1111, mk(4'b1111, 4'b1000, 1'b0, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 4'b0110, mk(4'b0110, 4'b0101, 1'b0, 1'b0));

        // Hold
        for (int k = 0; k < 5; k++)
            drive(1'b0, 1'b1, 1'b0, 4'b1001, mk(4'b0110, 4'b0101, 1'b0, 1'b0));
        drain();

        // Random en/up/load run with round-trip decode
        mb = 4'b0110;
        for (int k = 0; k < 60; k++) begin
            exp_t x;
            e  = 1'($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 7) == 0);
            lb = 4'($urandom_range(0, 15));
            mw = 1'b0;
            if (l) nb = lb;
            else if (e && u) begin nb = mb + 4'd1; mw = (mb == 4'd15); end
            else if (e)      begin nb = mb - 4'd1; mw = (mb == 4'd0);  end
            else nb = mb;
            x.b = nb; x.g = 4'd0; x.w = mw; x.chk_g = 1'b0;
            x.onebit = e && !l; x.rt = 1'b1;
            drive(e, u, l, lb, x);
            mb = nb;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
